// File: rtl/radix2_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : radix2_div_unit_pkg
// Brief   : Shared state encoding and handshake constants for the radix-2 divider.
// Revision: 1.0
// ============================================================================
package radix2_div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DZ   = 2'b01,
        ST_BUSY = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    localparam logic c_div_start            = 1'b1;
    localparam logic c_div_stop             = 1'b0;
    localparam logic c_div_result_ready     = 1'b1;
    localparam logic c_div_result_not_ready = 1'b0;

endpackage
`default_nettype wire

// File: rtl/radix2_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : radix2_div_unit_if
// Brief   : Request/response bundle between the EX stage and the divider.
// Revision: 1.0
// ============================================================================
interface radix2_div_unit_if #(
    parameter int WIDTH = 32
) ();
    import radix2_div_unit_pkg::*;

    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 dz_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, dz_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, dz_o
    );
endinterface
`default_nettype wire

// File: rtl/radix2_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : radix2_div_unit
// Brief   : Iterative restoring divider, one quotient bit per cycle, signed/unsigned.
// Revision: 1.0
// ============================================================================
module radix2_div_unit
    import radix2_div_unit_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int ZERO_LATENCY_DZ = 1
) (
    input  logic              clk,
    input  logic              rst,
    radix2_div_unit_if.slave  bus
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    div_state_e           r_state;
    div_state_e           w_state_next;
    logic                 r_signed;
    logic                 r_dvd_sign;
    logic                 r_dvs_sign;
    logic                 r_dz_pending;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_dividend_orig;
    logic [c_cnt_w-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dz_flag;

    logic                 w_accept;
    logic                 w_op1_neg;
    logic                 w_op2_neg;
    logic [WIDTH-1:0]     w_op1_mag;
    logic [WIDTH-1:0]     w_op2_mag;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quot_next;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [2*WIDTH-1:0]   w_final;
    logic                 w_done_entry;

    assign w_accept  = (r_state == ST_IDLE) && (bus.start_i == c_div_start) && !bus.annul_i;
    assign w_op1_neg = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
    assign w_op2_neg = bus.signed_div_i && bus.opdata2_i[WIDTH-1];
    assign w_op1_mag = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_op2_mag = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    // Partial remainder is kept below the divisor, so bit WIDTH of the trial
    // difference is exactly the borrow of the restoring subtraction.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_trial[WIDTH];
    assign w_rem_next  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

    assign w_quot_fix = (r_signed && (r_dvd_sign ^ r_dvs_sign)) ? -w_quot_next : w_quot_next;
    assign w_rem_fix  = (r_signed && r_dvd_sign) ? -w_rem_next : w_rem_next;
    assign w_final    = r_dz_pending ? {r_dividend_orig, {WIDTH{1'b1}}} : {w_rem_fix, w_quot_fix};

    assign w_done_entry = (w_state_next == ST_DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.opdata2_i == '0) ? ST_DZ : ST_BUSY;
                end
            end
            ST_DZ: begin
                if (bus.annul_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = (ZERO_LATENCY_DZ != 0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.annul_i) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == c_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_signed        <= 1'b0;
            r_dvd_sign      <= 1'b0;
            r_dvs_sign      <= 1'b0;
            r_dz_pending    <= 1'b0;
            r_quot          <= '0;
            r_rem           <= '0;
            r_divisor       <= '0;
            r_dividend_orig <= '0;
            r_count         <= '0;
            r_result        <= '0;
            r_dz_flag       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_signed        <= bus.signed_div_i;
                r_dvd_sign      <= bus.opdata1_i[WIDTH-1];
                r_dvs_sign      <= bus.opdata2_i[WIDTH-1];
                r_dz_pending    <= (bus.opdata2_i == '0);
                r_quot          <= w_op1_mag;
                r_rem           <= '0;
                r_divisor       <= w_op2_mag;
                r_dividend_orig <= bus.opdata1_i;
                r_count         <= '0;
            end else if (r_state == ST_BUSY) begin
                r_quot  <= w_quot_next;
                r_rem   <= w_rem_next;
                r_count <= r_count + c_cnt_w'(1);
            end
            if (w_done_entry) begin
                r_result  <= w_final;
                r_dz_flag <= r_dz_pending;
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.dz_o     = r_dz_flag;
    assign bus.ready_o  = (r_state == ST_DONE) ? c_div_result_ready : c_div_result_not_ready;
    assign bus.busy_o   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_radix2_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_radix2_div_unit
// Brief   : Directed self-checking bench for radix2_div_unit (32-bit and 8-bit).
// Revision: 1.0
// ============================================================================
module tb_radix2_div_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    radix2_div_unit_if #(.WIDTH(32)) bus32 ();
    radix2_div_unit_if #(.WIDTH(8))  bus8 ();

    radix2_div_unit #(.WIDTH(32), .ZERO_LATENCY_DZ(1)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    radix2_div_unit #(.WIDTH(8), .ZERO_LATENCY_DZ(0)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input bit use8);
        return use8 ? bus8.ready_o : bus32.ready_o;
    endfunction

    // exp_cyc counts the accepting cycle as cycle 1; <= 0 skips the latency check.
    task automatic run_op(input bit use8, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input bit exp_dz, input string tag);
        int   k;
        logic rdy;
        logic [31:0] gq;
        logic [31:0] gr;
        logic gd;
        @(negedge clk);
        if (use8) begin
            bus8.signed_div_i = sgn; bus8.opdata1_i = a[7:0]; bus8.opdata2_i = b[7:0];
            bus8.start_i = 1'b1;
        end else begin
            bus32.signed_div_i = sgn; bus32.opdata1_i = a; bus32.opdata2_i = b;
            bus32.start_i = 1'b1;
        end
        @(negedge clk);
        if (use8) begin
            bus8.start_i = 1'b0; bus8.signed_div_i = ~sgn;
            bus8.opdata1_i = ~a[7:0]; bus8.opdata2_i = b[7:0] ^ 8'h5A;
        end else begin
            bus32.start_i = 1'b0; bus32.signed_div_i = ~sgn;
            bus32.opdata1_i = ~a; bus32.opdata2_i = b ^ 32'h5A;
        end
        k   = 0;
        rdy = get_ready(use8);
        while (!rdy && k < 200) begin
            @(negedge clk);
            k++;
            rdy = get_ready(use8);
        end
        if (!rdy) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            if (use8) begin
                gq = {24'd0, bus8.result_o[7:0]};
                gr = {24'd0, bus8.result_o[15:8]};
                gd = bus8.dz_o;
            end else begin
                gq = bus32.result_o[31:0];
                gr = bus32.result_o[63:32];
                gd = bus32.dz_o;
            end
            if (exp_cyc > 0) check({tag, "_latency"}, 64'(k + 1), 64'(exp_cyc));
            check({tag, "_quot"}, {32'd0, gq}, {32'd0, exp_q});
            check({tag, "_rem"}, {32'd0, gr}, {32'd0, exp_r});
            check({tag, "_dz"}, {63'd0, gd}, {63'd0, exp_dz});
        end
        @(negedge clk);
        if (use8) check({tag, "_rdy_busy_after"}, {62'd0, bus8.ready_o, bus8.busy_o}, 64'd0);
        else      check({tag, "_rdy_busy_after"}, {62'd0, bus32.ready_o, bus32.busy_o}, 64'd0);
    endtask

    initial begin
        int  k;
        int  n_rdy;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus32.signed_div_i = 1'b0; bus32.opdata1_i = '0; bus32.opdata2_i = '0;
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        bus8.signed_div_i = 1'b0; bus8.opdata1_i = '0; bus8.opdata2_i = '0;
        bus8.start_i = 1'b0; bus8.annul_i = 1'b0;

        #3;
        check("rst_result32", bus32.result_o, 64'd0);
        check("rst_flags32", {61'd0, bus32.ready_o, bus32.busy_o, bus32.dz_o}, 64'd0);
        check("rst_out8", {45'd0, bus8.result_o, bus8.ready_o, bus8.busy_o, bus8.dz_o}, 64'd0);

        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;

        run_op(0, 0, 32'd100,        32'd7,        33, 32'd14,        32'd2,        0, "u100_7");
        run_op(0, 1, 32'hFFFFFFF9,   32'd2,        33, 32'hFFFFFFFD,  32'hFFFFFFFF, 0, "s_m7_2");
        run_op(0, 1, 32'h80000000,   32'hFFFFFFFF, 33, 32'h80000000,  32'd0,        0, "s_min_m1");
        run_op(0, 1, 32'd7,          32'hFFFFFFFE, 33, 32'hFFFFFFFD,  32'd1,        0, "s_7_m2");
        run_op(0, 0, 32'hFFFFFFF9,   32'd2,        33, 32'h7FFFFFFC,  32'd1,        0, "u_big_2");
        run_op(0, 0, 32'hFFFFFFFF,   32'h10,       33, 32'h0FFFFFFF,  32'hF,        0, "u_max_16");
        run_op(0, 0, 32'h1234,       32'd0,        2,  32'hFFFFFFFF,  32'h1234,     1, "dz32");

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        bus32.opdata1_i = 32'd50; bus32.opdata2_i = 32'd5; bus32.signed_div_i = 1'b0;
        bus32.start_i = 1'b1;
        @(negedge clk);
        bus32.start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_result", bus32.result_o, 64'd0);
        check("rst_mid_flags", {61'd0, bus32.ready_o, bus32.busy_o, bus32.dz_o}, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // start together with annul in IDLE must not launch anything.
        @(negedge clk);
        bus32.opdata1_i = 32'd9; bus32.opdata2_i = 32'd3;
        bus32.start_i = 1'b1; bus32.annul_i = 1'b1;
        @(negedge clk);
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        check("idle_annul_busy", {63'd0, bus32.busy_o}, 64'd0);

        run_op(0, 0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 0, "u100_7_again");

        // Annul on the tenth BUSY cycle.
        @(negedge clk);
        bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd3; bus32.start_i = 1'b1;
        @(negedge clk);
        bus32.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus32.annul_i = 1'b1;
        @(negedge clk);
        bus32.annul_i = 1'b0;
        check("annul_busy", {63'd0, bus32.busy_o}, 64'd0);
        n_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus32.ready_o) n_rdy++;
        end
        check("annul_no_ready", 64'(n_rdy), 64'd0);
        check("annul_result_held", bus32.result_o, {32'd2, 32'd14});
        run_op(0, 0, 32'd1000, 32'd3, 33, 32'd333, 32'd1, 0, "u1000_3");

        // Held start: DONE still returns to IDLE, then re-accepts.
        @(negedge clk);
        bus32.opdata1_i = 32'd20; bus32.opdata2_i = 32'd3; bus32.signed_div_i = 1'b0;
        bus32.start_i = 1'b1;
        k = 0;
        while (!bus32.ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("held_first_result", bus32.result_o, {32'd2, 32'd6});
        @(negedge clk);
        check("held_idle_after_done", {63'd0, bus32.busy_o}, 64'd0);
        @(negedge clk);
        check("held_restart", {63'd0, bus32.busy_o}, 64'd1);
        bus32.start_i = 1'b0;
        k = 0;
        while (!bus32.ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("held_second_result", bus32.result_o, {32'd2, 32'd6});

        run_op(1, 0, 32'd255, 32'd16, 9,  32'd15,  32'd15,  0, "w8_255_16");
        run_op(1, 0, 32'h12,  32'd0,  0,  32'hFF,  32'h12,  1, "w8_dz_iter");
        run_op(1, 1, 32'h80,  32'hFF, 9,  32'h80,  32'd0,   0, "w8_min_m1");
        run_op(1, 1, 32'h9C,  32'd7,  9,  32'hF2,  32'hFE,  0, "w8_m100_7");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/radix2_div_unit.md
RADIX2_DIV_UNIT -- requirements
Module: radix2_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/quotient/remainder width in bits (legal 4..64).
REQ-002 SHALL have parameter ZERO_LATENCY_DZ, default 1, meaning divide-by-zero completes without iterating.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port signed_div_i  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-006 SHALL have port opdata1_i  input  WIDTH  dividend.
REQ-007 SHALL have port opdata2_i  input  WIDTH  divisor.
REQ-008 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-009 SHALL have port annul_i  input  1  abort current operation.
REQ-010 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}.
REQ-011 SHALL have port ready_o  output  1  one-cycle completion strobe.
REQ-012 SHALL have port busy_o  output  1  high in every non-IDLE state.
REQ-013 SHALL have port dz_o  output  1  divide-by-zero flag, valid with ready_o.

Function
REQ-014 SHALL implement states IDLE, DZ, BUSY, DONE.
REQ-015 IDLE: start_i=1 and annul_i=0 SHALL latch operands and signed_div_i; next state DZ if opdata2_i==0, else BUSY.
REQ-016 IDLE with start_i=1 and annul_i=1 SHALL not start.
REQ-017 On start, in signed mode, operands SHALL be converted to magnitudes; operand signs SHALL be stored.
REQ-018 BUSY SHALL produce one quotient bit per cycle (restoring shift-subtract, WIDTH+1-bit partial remainder) for exactly WIDTH cycles, then enter DONE.
REQ-019 On DONE entry, quotient SHALL be negated if signed and operand signs differ; remainder SHALL be negated if signed and dividend negative; results truncated to WIDTH bits.
REQ-020 Signed most-negative / -1 SHALL yield quotient = most-negative value, remainder 0, no flag.
REQ-021 DZ (ZERO_LATENCY_DZ=1) SHALL last one cycle, then DONE with quotient all ones, remainder = original dividend, dz_o=1; with ZERO_LATENCY_DZ=0 it SHALL iterate through BUSY, producing the same values.
REQ-022 DONE SHALL last exactly one cycle with ready_o=1, then return to IDLE regardless of start_i.
REQ-023 Latency: start accepted at edge N SHALL give ready_o in cycle N+WIDTH+1 (N+2 for zero-latency DZ).
REQ-024 result_o and dz_o SHALL be registered, updated only on DONE entry, and held until the next DONE entry.
REQ-025 annul_i=1 in DZ or BUSY SHALL return to IDLE next cycle with no ready_o and result_o unchanged.
REQ-026 annul_i in DONE SHALL be ignored (completion stands).
REQ-027 Operand input changes after acceptance SHALL not affect the operation in progress.
REQ-028 A new start_i SHALL be accepted no earlier than the IDLE cycle after DONE (back-to-back interval WIDTH+2 cycles).

Reset
REQ-029 rst SHALL asynchronously force IDLE, result_o=0, ready_o=0, busy_o=0, dz_o=0, and clear internal registers, including mid-operation.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 State encoding and DivStart/DivStop and DivResultReady/NotReady constants SHALL live in the shared defines include.
REQ-032 No sub-module SHALL be instantiated; the block SHALL consist of a single FSM plus datapath.
REQ-033 The EX stage SHALL hold start_i high and request a stall until ready_o.

Verification
REQ-034 WIDTH=32, unsigned 100/7 -> ready_o in cycle N+33, quotient 14, remainder 2, dz_o=0.
REQ-035 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-036 Divisor 0, dividend 0x1234 -> ready_o at N+2, quotient 0xFFFFFFFF, remainder 0x1234, dz_o=1.
REQ-037 annul_i pulsed in BUSY cycle 10 -> IDLE next cycle, no ready_o, result_o keeps prior value; next start completes normally.
REQ-038 rst asserted mid-BUSY -> outputs zero immediately, without waiting for a clock edge.
REQ-039 WIDTH=8 instance, unsigned 255/16 -> ready_o at N+9, quotient 15, remainder 15.
